// File: rtl/alu_pkg.sv
// Shared datapath package for the result serializer.
// Contents:
//   STATE_W, state_t   - serializer FSM state encoding (IDLE=0 .. STOP=4)
//   WORD_W             - default datapath word width
//   SER_IDLE_LEVEL     - level driven on the serial line when no frame is active
package alu_pkg;

   localparam int STATE_W = 3;
   localparam int WORD_W  = 16;

   localparam logic SER_IDLE_LEVEL = 1'b1;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/result_serializer_if.sv
// Handshake and serial-line bundle between a word producer and the result serializer.
// Signals:
//   D      producer -> serializer   parallel word to transmit
//   load   producer -> serializer   transmit request, taken only while ready=1
//   ready  serializer -> producer   idle and able to accept a word
//   sout   serializer -> line       serial output, idles high
//   busy   serializer -> producer   frame in progress (complement of ready)
//   done   serializer -> producer   one-cycle pulse at frame completion
// Modports: master = producer side, slave = serializer side.
interface result_serializer_if
   import alu_pkg::*;
#(
   parameter int N = WORD_W
) ();

   logic [N-1:0] D;
   logic         load;
   logic         ready;
   logic         sout;
   logic         busy;
   logic         done;

   modport master (
      output D, load,
      input  ready, sout, busy, done
   );

   modport slave (
      input  D, load,
      output ready, sout, busy, done
   );

endinterface

// File: rtl/bit_tick_counter.sv
// Bit-period timer for the result serializer.
// Counts CLK cycles within one serial bit and flags the last cycle of the period.
// Ports:
//   CLK    in   system clock
//   reset  in   synchronous active-high reset
//   clear  in   reload the count to 0 on the next edge
//   tick   out  high during the last cycle of each BIT_TICKS-cycle bit period
module bit_tick_counter #(
   parameter int BIT_TICKS = 4
) (
   input  logic CLK,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(BIT_TICKS + 1);
   localparam logic [CW-1:0] LAST_TICK = CW'(BIT_TICKS - 1);

   logic [CW-1:0] r_cnt;

   // Decoded from the register only, so tick never depends on same-cycle inputs.
   assign tick = (r_cnt == LAST_TICK);

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear || tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/result_serializer.sv
// Parallel-in, serial-out framer: takes an N-bit word on a load/ready handshake and
// sends it LSB-first inside a start(0)/stop(1) frame, BIT_TICKS cycles per bit.
// Optional build macro RESULT_SERIALIZER_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
// Ports:
//   CLK    in     system clock, all state changes on the rising edge
//   reset  in     synchronous active-high reset
//   bus    slave  result_serializer_if: D, load in; ready, sout, busy, done out
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | line idle high, ready=1, waiting for load
//   ST_START  | start bit (0) for one bit period
//   ST_DATA   | shift register LSB on the line, N bit periods
//   ST_PARITY | even parity of the captured word (parity build only)
//   ST_STOP   | stop bit (1) for one bit period, then back to idle
module result_serializer
   import alu_pkg::*;
#(
   parameter int N         = WORD_W,
   parameter int BIT_TICKS = 4
) (
   input  logic                CLK,
   input  logic                reset,
   result_serializer_if.slave  bus
);

   localparam int BCW = $clog2(N + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(N - 1);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [N-1:0]   r_shift;
   logic [N-1:0]   w_shift_nxt;
   logic [BCW-1:0] r_bit_cnt;
   logic           w_tick;
   logic           w_clear;
   logic           w_accept;

   logic           r_sout;
   logic           r_ready;
   logic           r_busy;
   logic           r_done;
   logic           w_sout_nxt;
   logic           w_ready_nxt;
   logic           w_busy_nxt;
   logic           w_done_nxt;

`ifdef RESULT_SERIALIZER_PARITY_EN
   logic           r_parity;
`endif

   assign w_accept = (r_state == ST_IDLE) && bus.load;

   // The tick timer restarts on every state change; idle holds it at 0 so the
   // start bit always gets a full period.
   assign w_clear = (w_state_nxt != r_state) || (r_state == ST_IDLE);

   bit_tick_counter #(
      .BIT_TICKS (BIT_TICKS)
   ) u_bit_tick_counter (
      .CLK   (CLK),
      .reset (reset),
      .clear (w_clear),
      .tick  (w_tick)
   );

   // State register plus registered outputs.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_sout  <= SER_IDLE_LEVEL;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sout  <= w_sout_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_START;
         end
         ST_START: begin
            if (w_tick) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (w_tick && (r_bit_cnt == LAST_BIT)) begin
`ifdef RESULT_SERIALIZER_PARITY_EN
               w_state_nxt = ST_PARITY;
`else
               w_state_nxt = ST_STOP;
`endif
            end
         end
`ifdef RESULT_SERIALIZER_PARITY_EN
         ST_PARITY: begin
            if (w_tick) w_state_nxt = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (w_tick) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are computed from the next state so they can be registered without
   // adding a cycle of latency; the line shows the start bit right after accept.
   always_comb begin
      w_sout_nxt  = SER_IDLE_LEVEL;
      w_ready_nxt = (w_state_nxt == ST_IDLE);
      w_busy_nxt  = (w_state_nxt != ST_IDLE);
      w_done_nxt  = (r_state == ST_STOP) && (w_state_nxt == ST_IDLE);
      case (w_state_nxt)
         ST_START: w_sout_nxt = 1'b0;
         ST_DATA:  w_sout_nxt = w_shift_nxt[0];
`ifdef RESULT_SERIALIZER_PARITY_EN
         ST_PARITY: w_sout_nxt = r_parity;
`endif
         default:  w_sout_nxt = SER_IDLE_LEVEL;
      endcase
   end

   // D is only looked at on the accept edge; the register moves on each data tick.
   always_comb begin
      w_shift_nxt = r_shift;
      if (w_accept) begin
         w_shift_nxt = bus.D;
      end else if ((r_state == ST_DATA) && w_tick) begin
         w_shift_nxt = r_shift >> 1;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_shift <= w_shift_nxt;
         if (w_state_nxt != r_state) begin
            r_bit_cnt <= '0;
         end else if ((r_state == ST_DATA) && w_tick) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end
   end

`ifdef RESULT_SERIALIZER_PARITY_EN
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_parity <= 1'b0;
      end else if (w_accept) begin
         r_parity <= ^bus.D;
      end
   end
`endif

   assign bus.sout  = r_sout;
   assign bus.ready = r_ready;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;

endmodule
